decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter OPW, default 3, opcode width; decoded output width 2**OPW.
REQ-002 Parameter SCW, default 4, sequence counter width; timing output width 2**SCW.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 Port ir_load  input  1  capture ir_opcode and ir_i this cycle.
REQ-006 Port ir_opcode  input  OPW  opcode field of instruction register.
REQ-007 Port ir_i  input  1  indirect-addressing bit of instruction.
REQ-008 Port sc_inc  input  1  advance sequence counter.
REQ-009 Port sc_clr  input  1  return sequence counter to 0.
REQ-010 Port halt  input  1  request stop; sticky.
REQ-011 Port d  output  2**OPW  one-hot decoded opcode, all-zero when invalid.
REQ-012 Port t  output  2**SCW  one-hot timing signal, t[n] high when counter equals n.
REQ-013 Port i_bit  output  1  registered indirect bit.
REQ-014 Port sc_value  output  SCW  current counter value.
REQ-015 Port wrap  output  1  one-cycle pulse after counter rolls over max to 0.
REQ-016 Port halted  output  1  high while sequencer is stopped.

Function
REQ-017 Opcode register and i_bit SHALL load on ir_load when not halted; d reflects new opcode the cycle after load (latency 1).
REQ-018 d SHALL be driven combinationally from the opcode register gated by an internal valid flag; exactly one bit high when valid, all zero otherwise.
REQ-019 Valid flag SHALL clear on reset and set on first accepted ir_load; never cleared otherwise.
REQ-020 Counter update priority SHALL be: reset > halted (hold) > sc_clr (to 0) > sc_inc (+1) > hold.
REQ-021 Counter SHALL increment modulo 2**SCW; inc at value 2**SCW-1 yields 0 and asserts wrap for exactly the following cycle.
REQ-022 wrap SHALL be low in every cycle not following a rollover, including after sc_clr at max value.
REQ-023 t SHALL be the one-hot decode of sc_value, exactly one bit high at all times including reset.
REQ-024 Simultaneous ir_load and sc_clr/sc_inc SHALL both take effect in the same edge.
REQ-025 halt SHALL set halted at the next edge; while halted, counter, opcode register, i_bit and valid SHALL hold and sc_clr, sc_inc, ir_load SHALL be ignored.
REQ-026 halted SHALL clear only on reset; halt asserted with sc_clr in one cycle: halt wins, counter holds value of that cycle's input to halted (sc_clr applies only if halted still low at that edge, i.e. it does apply that edge).
REQ-027 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 On reset: sc_value=0, t=1 (t[0]), d=0, i_bit=0, wrap=0, halted=0, valid=0, opcode register=0.
REQ-029 Reset asserted mid-sequence or while halted SHALL override all other inputs in that cycle.

Verification
REQ-030 Reset, then ir_load with ir_opcode=5, ir_i=1 -> next cycle d=8'b0010_0000, i_bit=1; before load d=0.
REQ-031 Defaults, 16 consecutive sc_inc from 0 -> t walks t[0]..t[15], then sc_value=0, t=1, wrap=1 for one cycle only.
REQ-032 Counter at 3, sc_clr and sc_inc together -> sc_value=0, t=1, wrap=0.
REQ-033 Counter at 7, halt pulse -> halted=1; subsequent sc_inc, sc_clr, ir_load opcode=2 -> sc_value stays 7, d unchanged; reset -> REQ-028 values.
REQ-034 OPW=4, SCW=2 build: ir_load opcode=15 -> d[15]=1 only; 4 sc_inc from 0 -> wrap pulse, sc_value=0.

Source files
------------

// File: rtl/decode_sequencer.sv
// Instruction decode and timing sequencer: opcode/indirect-bit register with
// one-hot decode, modulo sequence counter with one-hot timing and a sticky halt.
module decode_sequencer #(
  parameter int unsigned OPW = 3,
  parameter int unsigned SCW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ir_load,
  input  logic [OPW-1:0]      ir_opcode,
  input  logic                ir_i,
  input  logic                sc_inc,
  input  logic                sc_clr,
  input  logic                halt,
  output logic [2**OPW-1:0]   d,
  output logic [2**SCW-1:0]   t,
  output logic                i_bit,
  output logic [SCW-1:0]      sc_value,
  output logic                wrap,
  output logic                halted
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic           i_bit_q, i_bit_d;
  logic           valid_q, valid_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic           wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      opcode_q <= '0;
      i_bit_q  <= 1'b0;
      valid_q  <= 1'b0;
      sc_q     <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      i_bit_q  <= i_bit_d;
      valid_q  <= valid_d;
      sc_q     <= sc_d;
      wrap_q   <= wrap_d;
    end
  end

  // halt is judged against the registered state, so a clr/inc/load arriving
  // in the same cycle as halt still takes effect on that edge.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    i_bit_d  = i_bit_q;
    valid_d  = valid_q;
    sc_d     = sc_q;
    wrap_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (halt) state_d = ST_HALT;
        if (ir_load) begin
          opcode_d = ir_opcode;
          i_bit_d  = ir_i;
          valid_d  = 1'b1;
        end
        if (sc_clr) begin
          sc_d = '0;
        end else if (sc_inc) begin
          sc_d   = sc_q + SCW'(1);
          wrap_d = (sc_q == '1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    d = '0;
    if (valid_q) d[opcode_q] = 1'b1;
  end

  always_comb begin
    t = '0;
    t[sc_q] = 1'b1;
  end

  assign i_bit    = i_bit_q;
  assign sc_value = sc_q;
  assign wrap     = wrap_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: default build plus an OPW=4/SCW=2 build.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_load, ir_i, sc_inc, sc_clr, halt;
  logic [2:0]  ir_opcode;
  logic [7:0]  d;
  logic [15:0] t;
  logic        i_bit, wrap, halted;
  logic [3:0]  sc_value;

  logic        p_ir_load, p_ir_i, p_sc_inc, p_sc_clr, p_halt;
  logic [3:0]  p_ir_opcode;
  logic [15:0] p_d;
  logic [3:0]  p_t;
  logic        p_i_bit, p_wrap, p_halted;
  logic [1:0]  p_sc_value;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_sequencer dut (
    .clk(clk), .reset(reset), .ir_load(ir_load), .ir_opcode(ir_opcode),
    .ir_i(ir_i), .sc_inc(sc_inc), .sc_clr(sc_clr), .halt(halt),
    .d(d), .t(t), .i_bit(i_bit), .sc_value(sc_value), .wrap(wrap),
    .halted(halted)
  );

  decode_sequencer #(.OPW(4), .SCW(2)) dut_p (
    .clk(clk), .reset(reset), .ir_load(p_ir_load), .ir_opcode(p_ir_opcode),
    .ir_i(p_ir_i), .sc_inc(p_sc_inc), .sc_clr(p_sc_clr), .halt(p_halt),
    .d(p_d), .t(p_t), .i_bit(p_i_bit), .sc_value(p_sc_value), .wrap(p_wrap),
    .halted(p_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ir_load = 0; ir_i = 0; ir_opcode = '0; sc_inc = 0; sc_clr = 0; halt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sc"}, 32'(sc_value), 32'd0);
    chk({tag, "_t"}, 32'(t), 32'h1);
    chk({tag, "_d"}, 32'(d), 32'h0);
    chk({tag, "_ibit"}, 32'(i_bit), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    idle();
    p_ir_load = 0; p_ir_i = 0; p_ir_opcode = '0; p_sc_inc = 0; p_sc_clr = 0; p_halt = 0;
    reset = 1;
    #1; tick(); tick();
    reset = 0;
    check_reset_state("rst");

    // load opcode 5 with indirect bit
    ir_load = 1; ir_opcode = 3'd5; ir_i = 1;
    chk("pre_load_d", 32'(d), 32'h0);
    tick(); idle();
    chk("load_d", 32'(d), 32'h20);
    chk("load_ibit", 32'(i_bit), 32'd1);

    // 16 increments walk t and roll over with a single wrap pulse
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("walk_t%0d", k), 32'(t), 32'h1 << k);
      chk($sformatf("walk_wrap%0d", k), 32'(wrap), 32'd0);
      sc_inc = 1; tick();
    end
    sc_inc = 0;
    chk("roll_sc", 32'(sc_value), 32'd0);
    chk("roll_t", 32'(t), 32'h1);
    chk("roll_wrap", 32'(wrap), 32'd1);
    tick();
    chk("roll_wrap_gone", 32'(wrap), 32'd0);

    // clr has priority over inc at value 3
    sc_inc = 1; tick(); tick(); tick();
    chk("at3_sc", 32'(sc_value), 32'd3);
    sc_clr = 1; tick(); idle();
    chk("clr3_sc", 32'(sc_value), 32'd0);
    chk("clr3_t", 32'(t), 32'h1);
    chk("clr3_wrap", 32'(wrap), 32'd0);

    // clr at max value gives no wrap
    sc_inc = 1;
    for (int k = 0; k < 15; k++) tick();
    chk("at15_sc", 32'(sc_value), 32'd15);
    sc_clr = 1; tick(); idle();
    chk("clr15_sc", 32'(sc_value), 32'd0);
    chk("clr15_wrap", 32'(wrap), 32'd0);

    // load and inc on the same edge
    ir_load = 1; ir_opcode = 3'd3; ir_i = 0; sc_inc = 1; tick(); idle();
    chk("both_d", 32'(d), 32'h08);
    chk("both_ibit", 32'(i_bit), 32'd0);
    chk("both_sc", 32'(sc_value), 32'd1);

    // halt at 7, then everything ignored
    sc_inc = 1;
    for (int k = 0; k < 6; k++) tick();
    sc_inc = 0;
    chk("at7_sc", 32'(sc_value), 32'd7);
    halt = 1; tick(); halt = 0;
    chk("halt_flag", 32'(halted), 32'd1);
    sc_inc = 1; tick(); idle();
    sc_clr = 1; tick(); idle();
    ir_load = 1; ir_opcode = 3'd2; ir_i = 1; tick(); idle();
    chk("halt_sc", 32'(sc_value), 32'd7);
    chk("halt_t", 32'(t), 32'h80);
    chk("halt_d", 32'(d), 32'h08);
    chk("halt_ibit", 32'(i_bit), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // reset while halted overrides concurrent inputs
    reset = 1; sc_inc = 1; ir_load = 1; ir_opcode = 3'd6; ir_i = 1; halt = 1;
    tick();
    reset = 0; idle();
    check_reset_state("rst2");

    // halt with clr in the same cycle: clr still applies on that edge
    sc_inc = 1; tick(); tick(); tick(); tick(); tick(); sc_inc = 0;
    chk("at5_sc", 32'(sc_value), 32'd5);
    halt = 1; sc_clr = 1; tick(); idle();
    chk("haltclr_flag", 32'(halted), 32'd1);
    chk("haltclr_sc", 32'(sc_value), 32'd0);
    sc_inc = 1; tick(); idle();
    chk("haltclr_hold", 32'(sc_value), 32'd0);
    reset = 1; tick(); reset = 0;

    // parameterised build OPW=4, SCW=2
    chk("p_rst_d", 32'(p_d), 32'h0);
    chk("p_rst_t", 32'(p_t), 32'h1);
    p_ir_load = 1; p_ir_opcode = 4'd15; p_ir_i = 1; tick(); p_ir_load = 0;
    chk("p_load_d", 32'(p_d), 32'h8000);
    chk("p_load_ibit", 32'(p_i_bit), 32'd1);
    p_sc_inc = 1; tick(); tick(); tick();
    chk("p_at3_t", 32'(p_t), 32'h8);
    chk("p_at3_wrap", 32'(p_wrap), 32'd0);
    tick(); p_sc_inc = 0;
    chk("p_roll_sc", 32'(p_sc_value), 32'd0);
    chk("p_roll_wrap", 32'(p_wrap), 32'd1);
    tick();
    chk("p_roll_wrap_gone", 32'(p_wrap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
